// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
// Holds the default geometry and the two-state FSM encoding used by
// fifo_wr_arbiter.
package fifo_arb_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefMaxBurst  = 4;

  typedef logic [0:0] state_t;

  localparam state_t StIdle  = 1'b0;
  localparam state_t StBurst = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the requester that is given lowest priority
//   valid - high when at least one req bit is set
//   index - first requester with req set, searching upward from last+1
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  output logic               valid,
  output logic [IdxW-1:0]    index
);

  logic [IdxW-1:0] cand;

  // Offsets 1..NUM_REQ visit every requester once, ending on last itself.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the asynchronous FIFO's single write port
// among NUM_REQ requesters in the write clock domain. Bursts are bounded
// to MAX_BURST accepted beats; writes are held off while the FIFO is full.
// Ports:
//   wr_clk, rst    - write-domain clock, async active-high reset
//   req, req_data  - per-requester level request and packed data
//   gnt            - one-hot grant; a beat moves when req[i] & gnt[i]
//   fifo_full      - FIFO full flag, gates the grant combinationally
//   fifo_overflow  - FIFO overflow flag, latched into err_overflow
//   wr_en, wdata   - FIFO write port
//   owner          - current or most recent burst owner
//   err_overflow   - sticky overflow error, cleared only by rst
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned MAX_BURST  = DefMaxBurst
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_overflow,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          err_overflow
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  state_t          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_owner_q, last_owner_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            err_q;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] pick_last;
  logic            last_beat;
  logic            burst_end;

  // In BURST the handoff pick treats the current owner as lowest priority;
  // in IDLE the owner register already equals last_owner or its reset value.
  assign pick_last = (state_q == StBurst) ? owner_q : last_owner_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .last  (pick_last),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Write port: purely combinational so an accepted beat lands on this edge.
  always_comb begin
    gnt   = '0;
    wr_en = 1'b0;
    wdata = '0;
    if (state_q == StBurst) begin
      gnt[owner_q] = req[owner_q] & ~fifo_full;
      wr_en        = |(req & gnt);
      if (wr_en) begin
        wdata = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign last_beat = wr_en && (burst_cnt_q == CntW'(MAX_BURST - 1));
  // A full-stalled cycle keeps req[owner] high and accepts nothing: no exit.
  assign burst_end = !req[owner_q] || last_beat;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if (wr_en) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (burst_end) begin
          last_owner_d = owner_q;
          if (pick_valid) begin
            owner_d     = pick_idx;
            burst_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IdxW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      err_q        <= err_q | fifo_overflow;
    end
  end

  assign owner        = owner_q;
  assign err_overflow = err_q;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the write clock domain. Each requester is granted bounded bursts of at most MAX_BURST beats. The block watches the FIFO's `full` so that it never issues a write into a full FIFO. A sticky error flag records any overflow the FIFO reports.

## Interface
- DATA_WIDTH, 8: width of each data beat; must match the FIFO's DATA_WIDTH.
- NUM_REQ, 4: number of requesters; must be at least 2.
- MAX_BURST, 4: maximum number of accepted beats per grant; must be at least 1.

- wr_clk  in  1  FIFO write-domain clock. This is the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, level. A requester holds it while it has data.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data. Requester i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NUM_REQ  one-hot grant. A beat transfers in any cycle where req[i] and gnt[i] are both high.
- fifo_full  in  1  FIFO `full`.
- fifo_overflow  in  1  FIFO `overflow`.
- wr_en  out  1  drives FIFO `wr_en`.
- wdata  out  DATA_WIDTH  drives FIFO `wdata`.
- owner  out  $clog2(NUM_REQ)  index of the current or most recent owner.
- err_overflow  out  1  sticky; set when the FIFO reports an overflow.

## Operation
- FSM has two states: IDLE and BURST. Registers:
  - state
  - owner
  - last_owner
  - burst_cnt, width $clog2(MAX_BURST+1)
  - err_overflow
- Reset values:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1 (so requester 0 wins first), burst_cnt=0, err_overflow=0.
  - gnt=0, wr_en=0, wdata=0.
- Round-robin pick: the first requester with req high, searching from last_owner+1 upward modulo NUM_REQ. last_owner itself is checked last.
- IDLE:
  - If any req bit is high, load owner from the pick, clear burst_cnt, and go to BURST.
  - There is no grant in the cycle the request is seen (one arbitration cycle).
- BURST:
  - gnt[owner] = req[owner] & ~fifo_full. All other gnt bits are 0.
  - wr_en = |(req & gnt).
  - wdata = req_data slice of owner when wr_en is high, else 0.
  - Each accepted beat increments burst_cnt. Cycles stalled by fifo_full neither count nor end the burst.
- Exit from BURST occurs when either:
  - req[owner] is low, with no write in that cycle; or
  - a beat is accepted with burst_cnt == MAX_BURST-1.
- On exit:
  - last_owner is set to owner.
  - If a new pick is valid from the current req vector, with the old owner as lowest priority, load it and stay in BURST with burst_cnt=0. This is a direct handoff with no bubble.
  - Otherwise go to IDLE.
- err_overflow is set on any wr_clk edge where fifo_overflow=1. It is cleared only by rst.
- The block never asserts wr_en while fifo_full=1.

## Timing
- gnt, wr_en and wdata are combinational from registered state plus req and fifo_full. There is no write latency: an accepted beat reaches the FIFO on the same edge.
- First grant arrives 1 cycle after req rises from IDLE.
- Handoff between owners takes 0 bubble cycles.
- With req held continuously, a single requester gets MAX_BURST beats per grant, then re-wins immediately if no other requester is pending.
- fifo_full falls → gnt rises combinationally in the same cycle.
- Reset asserted mid-burst: gnt and wr_en drop immediately (asynchronous), with no partial state retained. After release, arbitration restarts from requester 0.
- Requesters must hold req_data stable while req is high and no beat has been accepted.

## Structure
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - the default DATA_WIDTH, NUM_REQ and MAX_BURST constants.
- One sub-module, rr_pick:
  - combinational round-robin priority picker;
  - inputs: req vector, last_owner;
  - outputs: valid, index.
  - It is used for both the IDLE pick and the handoff pick.

## Test plan
All scenarios use NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8, a 16-deep FIFO, and wr_clk at 10 ns.
- **Reset:** rst high for 2 cycles with req=4'b1111 → gnt=0, wr_en=0, owner=0, err_overflow=0. After release, gnt=4'b0001 one cycle later.
- **Single requester:** req=4'b0100 for 6 beats, data 0x10..0x15 → 4 beats, then immediate regrant to requester 2, then 2 beats. wr_en is high for 6 consecutive cycles after the arbitration cycle.
- **All requesters:** req=4'b1111 held → grant order 0,1,2,3,0, with 4 beats each and no bubble after the first cycle.
- **Fill:** req0 offers 20 beats with no reads → exactly 16 writes, then gnt=0 while full. fifo_overflow never asserts and err_overflow stays 0. One read drains a slot → exactly one more beat is accepted.
- **Drop mid-burst:** req1 drops after 2 beats while req3 is pending → that cycle has no write, and gnt=4'b1000 in the next cycle.
- **Overflow:** force fifo_overflow=1 for 1 cycle → err_overflow=1 and stays set until rst.
